pwm_multi_channel: RTL and testbench
====================================

# pwm_multi_channel

Parametrised multi-channel PWM generator, the successor to the fixed 60 % duty-cycle divider. One shared period counter drives CHANNELS outputs, each with its own programmable duty and polarity, in edge-aligned or center-aligned mode. New settings are double-buffered and applied only at a period boundary, so outputs are glitch-free. It sits between the control register block and the motor/LED driver pins.

## Interface
- WIDTH, 8: width of the period counter, period and duty values.
- CHANNELS, 4: number of PWM outputs.
- RST_PERIOD, 10: active period after reset.
- RST_DUTY, 6: active duty of every channel after reset.
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  high = run; low = counter held at 0, outputs idle.
- load  input  1  one-cycle strobe; captures period_in, duty_in, pol_in, center_in into shadow registers.
- period_in  input  WIDTH  new period in counts.
- duty_in  input  CHANNELS*WIDTH  new duties; channel i at bits [i*WIDTH +: WIDTH].
- pol_in  input  CHANNELS  per-channel output inversion.
- center_in  input  1  0 = edge-aligned, 1 = center-aligned.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_tick  output  1  one-cycle pulse at each period boundary.
- update_pending  output  1  shadow holds values not yet applied.

## Operation
- Active set: per, duty[i], pol[i], center. Shadow set has the same fields plus a pending flag.
- Edge mode: cnt counts 0..per-1, then wraps to 0. Boundary = cnt == per-1.
- Center mode: direction bit dir; counts up 0..per-1, holds per-1 once more while dir flips to down, counts down to 0, holds 0 once more while dir flips to up. Period = 2*per cycles. Boundary = cnt == 0 with dir down.
- Raw compare: raw[i] = (cnt < duty[i]). duty[i] = 0 gives always low; duty[i] >= per gives always high.
- pwm_out[i] is registered as raw[i] XOR pol[i] when enable is high, and as pol[i] when enable is low.
- per = 0: the counter is held at 0, raw = 0, and period_tick never fires. per = 1 in edge mode: boundary every cycle.
- load: the shadow is written and pending is set. A second load before the boundary overwrites the shadow; the last one wins.
- At a boundary with pending = 1: active is set from shadow, cnt goes to 0, dir goes to up, and pending clears. If load coincides with the boundary, the newly presented inputs are applied directly (bypass), and pending ends at 0.
- enable low: cnt = 0 and dir = up. If pending is set, shadow is applied on the next clock and pending clears.
- enable rising: counting starts from cnt = 0 on that cycle.
- Arithmetic: all compares are unsigned, WIDTH bits. The counter never exceeds per-1, so no overflow.

## Timing
- Reset values:
  - cnt = 0, dir = up, pending = 0.
  - per = RST_PERIOD, every duty[i] = RST_DUTY, pol = 0, center = 0.
  - Shadow equals active.
  - pwm_out = 0, period_tick = 0, update_pending = 0.
- pwm_out lags cnt by one clock: the value seen in cycle n+1 reflects cnt in cycle n.
- period_tick is registered from (enable && boundary && per != 0). It is high for one cycle, coincident with pwm_out showing the last count of the period.
- update_pending rises the cycle after load. It falls the cycle after the boundary that applies the shadow.
- Asserting reset_n low mid-period forces all reset values immediately, without waiting for a clock. A pending update is discarded.
- After reset_n deasserts with enable high, the first pwm_out high appears 1 cycle later.

## Test plan
- Reset, enable = 1, no load: pwm_out[0] repeats 6 high then 4 low (period 10). period_tick fires every 10 cycles.
- load with period_in = 8 and duty0 = 2 mid-period: the old 6/4 pattern finishes its period; then 2 high / 6 low. update_pending is high until the boundary.
- duty0 = 0, duty1 = 8, duty2 = 200 with per = 8: ch0 constant 0; ch1 and ch2 constant 1. pol_in = 4'b0001: ch0 constant 1.
- center_in = 1, per = 4, duty0 = 1: cnt runs 0,1,2,3,3,2,1,0. pwm_out[0] is high 2 of 8 cycles, contiguous across the boundary. period_tick fires every 8 cycles.
- Drop enable mid-period, with pol = 4'b0010: pwm_out = 4'b0010 and cnt is held at 0. A load while disabled is applied within 1 cycle. Raising enable restarts from cnt = 0.
- Assert reset_n low asynchronously mid-period with an update pending: outputs are 0 immediately. After release, the pattern returns to 6/4 and update_pending = 0.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator.
// One shared period counter feeds CHANNELS compare units. Each channel has its
// own duty and polarity. The counter runs edge-aligned (sawtooth) or
// center-aligned (triangle). New settings land in a shadow set and move to the
// active set only at a period boundary, or right away while disabled, so a
// running output never glitches mid-period.
module pwm_multi_channel #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned RST_PERIOD = 10,
    parameter int unsigned RST_DUTY   = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic [CHANNELS-1:0]       pol_in,
    input  logic                      center_in,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      update_pending
);

    localparam logic [WIDTH-1:0] RstPer  = WIDTH'(RST_PERIOD);
    localparam logic [WIDTH-1:0] RstDuty = WIDTH'(RST_DUTY);

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // Active set
    logic [WIDTH-1:0]                per_q, per_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_q, duty_d;
    logic [CHANNELS-1:0]             pol_q, pol_d;
    logic                            center_q, center_d;

    // Shadow set
    logic [WIDTH-1:0]                sh_per_q, sh_per_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  sh_duty_q, sh_duty_d;
    logic [CHANNELS-1:0]             sh_pol_q, sh_pol_d;
    logic                            sh_center_q, sh_center_d;
    logic                            pending_q, pending_d;

    // Counter and registered outputs
    logic [WIDTH-1:0]                cnt_q, cnt_d;
    dir_e                            dir_q, dir_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic                            tick_q, tick_d;

    logic [WIDTH-1:0]                per_m1;
    logic                            per_zero;
    logic                            at_top;
    logic                            boundary;
    logic                            apply;
    logic [CHANNELS-1:0]             raw;

    // Period boundary detection and the decision to commit new settings.
    always_comb begin
        per_m1   = per_q - WIDTH'(1);
        per_zero = (per_q == '0);
        at_top   = (cnt_q == per_m1);
        // With a zero period every cycle counts as a boundary so that a queued
        // update can still take effect; period_tick is masked separately.
        if (per_zero) begin
            boundary = 1'b1;
        end else if (center_q) begin
            boundary = (cnt_q == '0) && (dir_q == DirDown);
        end else begin
            boundary = at_top;
        end
        apply = (pending_q || load) && (!enable || boundary);
    end

    // Shadow capture, active-set commit (with load bypass) and pending flag.
    always_comb begin
        sh_per_d    = sh_per_q;
        sh_duty_d   = sh_duty_q;
        sh_pol_d    = sh_pol_q;
        sh_center_d = sh_center_q;
        per_d       = per_q;
        duty_d      = duty_q;
        pol_d       = pol_q;
        center_d    = center_q;
        pending_d   = pending_q;

        if (load) begin
            sh_per_d    = period_in;
            sh_duty_d   = duty_in;
            sh_pol_d    = pol_in;
            sh_center_d = center_in;
        end

        if (apply) begin
            // A load on the commit cycle wins over the older shadow contents.
            if (load) begin
                per_d    = period_in;
                duty_d   = duty_in;
                pol_d    = pol_in;
                center_d = center_in;
            end else begin
                per_d    = sh_per_q;
                duty_d   = sh_duty_q;
                pol_d    = sh_pol_q;
                center_d = sh_center_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Next counter value and direction for edge and center alignment.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable || per_zero || boundary) begin
            cnt_d = '0;
            dir_d = DirUp;
        end else if (!center_q) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dir_q == DirUp) begin
            // Dwell one extra cycle at the top while turning around.
            if (at_top) begin
                dir_d = DirDown;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Per-channel compare, polarity and idle level; period tick generation.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = !per_zero && (cnt_q < duty_q[i]);
        end
        pwm_d  = enable ? (raw ^ pol_q) : pol_q;
        tick_d = enable && boundary && !per_zero;
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            dir_q <= DirUp;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Active and shadow setting registers; reset discards any pending update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_q       <= RstPer;
            duty_q      <= {CHANNELS{RstDuty}};
            pol_q       <= '0;
            center_q    <= 1'b0;
            sh_per_q    <= RstPer;
            sh_duty_q   <= {CHANNELS{RstDuty}};
            sh_pol_q    <= '0;
            sh_center_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            per_q       <= per_d;
            duty_q      <= duty_d;
            pol_q       <= pol_d;
            center_q    <= center_d;
            sh_per_q    <= sh_per_d;
            sh_duty_q   <= sh_duty_d;
            sh_pol_q    <= sh_pol_d;
            sh_center_q <= sh_center_d;
            pending_q   <= pending_d;
        end
    end

    // Registered outputs, one clock behind the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
        end
    end

    assign pwm_out        = pwm_q;
    assign period_tick    = tick_q;
    assign update_pending = pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel (default parameters).
module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [7:0]  period_in;
    logic [31:0] duty_in;
    logic [3:0]  pol_in;
    logic        center_in;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic        update_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]      per;
        logic [31:0]     duty;
        logic [3:0]      pol;
        logic            center;
        int              len;
        logic [3:0][8:0] hi;
    } vec_t;

    vec_t vecs[7];

    pwm_multi_channel dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .load           (load),
        .period_in      (period_in),
        .duty_in        (duty_in),
        .pol_in         (pol_in),
        .center_in      (center_in),
        .pwm_out        (pwm_out),
        .period_tick    (period_tick),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a configuration with a one-cycle load strobe.
    task automatic do_load(input logic [7:0] p, input logic [31:0] d, input logic [3:0] pl,
                           input logic c);
        period_in = p;
        duty_in   = d;
        pol_in    = pl;
        center_in = c;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_pending_low(input string name);
        int n = 0;
        while (update_pending && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(update_pending), 0);
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 600);
        check(name, int'(period_tick), 1);
    endtask

    initial begin
        int c;
        int hic[4];
        int ticks;
        int last_tick;
        int cs[8];
        logic [3:0] exp_pwm;

        vecs[0] = '{per: 8'd8, duty: {8'd3, 8'd200, 8'd8, 8'd0}, pol: 4'b0000, center: 1'b0,
                    len: 8, hi: {9'd3, 9'd8, 9'd8, 9'd0}};
        vecs[1] = '{per: 8'd8, duty: {8'd3, 8'd200, 8'd8, 8'd0}, pol: 4'b0001, center: 1'b0,
                    len: 8, hi: {9'd3, 9'd8, 9'd8, 9'd8}};
        vecs[2] = '{per: 8'd4, duty: {8'd4, 8'd2, 8'd0, 8'd1}, pol: 4'b0000, center: 1'b1,
                    len: 8, hi: {9'd8, 9'd4, 9'd0, 9'd2}};
        vecs[3] = '{per: 8'd4, duty: {8'd4, 8'd2, 8'd0, 8'd1}, pol: 4'b1010, center: 1'b1,
                    len: 8, hi: {9'd0, 9'd4, 9'd8, 9'd2}};
        vecs[4] = '{per: 8'd1, duty: {8'd0, 8'd5, 8'd0, 8'd1}, pol: 4'b0000, center: 1'b0,
                    len: 1, hi: {9'd0, 9'd1, 9'd0, 9'd1}};
        vecs[5] = '{per: 8'd255, duty: {8'd255, 8'd254, 8'd128, 8'd1}, pol: 4'b0000,
                    center: 1'b0, len: 255, hi: {9'd255, 9'd254, 9'd128, 9'd1}};
        vecs[6] = '{per: 8'd3, duty: {8'd1, 8'd3, 8'd0, 8'd2}, pol: 4'b0000, center: 1'b1,
                    len: 6, hi: {9'd2, 9'd6, 9'd0, 9'd4}};

        reset_n   = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        period_in = '0;
        duty_in   = '0;
        pol_in    = '0;
        center_in = 1'b0;

        #1;
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset period_tick", int'(period_tick), 0);
        check("reset update_pending", int'(update_pending), 0);

        // Default 6/4 pattern, then a mid-period load of period 8 / duty0 2.
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k <= 30) begin
                c       = (k - 1) % 10;
                exp_pwm = (c < 6) ? 4'b1111 : 4'b0000;
                check($sformatf("pat pwm k=%0d", k), int'(pwm_out), int'(exp_pwm));
                check($sformatf("pat tick k=%0d", k), int'(period_tick), int'(c == 9));
            end else begin
                c       = (k - 31) % 8;
                exp_pwm = {{3{c < 6}}, c < 2};
                check($sformatf("newper pwm k=%0d", k), int'(pwm_out), int'(exp_pwm));
                check($sformatf("newper tick k=%0d", k), int'(period_tick), int'(c == 7));
            end
            if (k >= 21 && k <= 31) begin
                check($sformatf("pending k=%0d", k), int'(update_pending),
                      int'(k >= 24 && k <= 29));
            end
            if (k == 23) begin
                period_in = 8'd8;
                duty_in   = {8'd6, 8'd6, 8'd6, 8'd2};
                pol_in    = 4'b0000;
                center_in = 1'b0;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
        end

        // Table of configurations: measure one full period after sync.
        for (int v = 0; v < 7; v++) begin
            do_load(vecs[v].per, vecs[v].duty, vecs[v].pol, vecs[v].center);
            wait_pending_low($sformatf("vec%0d apply", v));
            wait_tick($sformatf("vec%0d sync", v));
            for (int ch = 0; ch < 4; ch++) hic[ch] = 0;
            ticks     = 0;
            last_tick = 0;
            for (int j = 0; j < vecs[v].len; j++) begin
                @(negedge clk);
                for (int ch = 0; ch < 4; ch++) hic[ch] += int'(pwm_out[ch]);
                ticks    += int'(period_tick);
                last_tick = int'(period_tick);
            end
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("vec%0d ch%0d high count", v, ch), hic[ch],
                      int'(vecs[v].hi[ch]));
            end
            check($sformatf("vec%0d tick count", v), ticks, 1);
            check($sformatf("vec%0d tick at end", v), last_tick, 1);
        end

        // Center mode exact sequence: cnt 0,1,2,3,3,2,1,0.
        cs = '{0, 1, 2, 3, 3, 2, 1, 0};
        do_load(8'd4, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000, 1'b1);
        wait_pending_low("center apply");
        wait_tick("center sync");
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            c = cs[j % 8];
            for (int i = 0; i < 4; i++) exp_pwm[i] = (c < i + 1);
            check($sformatf("center pwm j=%0d", j), int'(pwm_out), int'(exp_pwm));
            check($sformatf("center tick j=%0d", j), int'(period_tick), int'(j % 8 == 7));
        end

        // Zero period: outputs low, no ticks.
        do_load(8'd0, {4{8'd5}}, 4'b0000, 1'b0);
        wait_pending_low("per0 apply");
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check($sformatf("per0 pwm j=%0d", j), int'(pwm_out), 0);
            check($sformatf("per0 tick j=%0d", j), int'(period_tick), 0);
        end

        // Enable drop with polarity, load while disabled, restart.
        do_load(8'd8, {4{8'd4}}, 4'b0010, 1'b0);
        wait_pending_low("en apply");
        wait_tick("en sync");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("en run pwm j=%0d", j), int'(pwm_out), int'(4'b1101));
        end
        enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("dis pwm j=%0d", j), int'(pwm_out), int'(4'b0010));
            check($sformatf("dis tick j=%0d", j), int'(period_tick), 0);
        end
        pol_in = 4'b0100;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("dis load pwm old pol", int'(pwm_out), int'(4'b0010));
        check("dis load pending", int'(update_pending), 0);
        @(negedge clk);
        check("dis load pwm new pol", int'(pwm_out), int'(4'b0100));
        enable = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            exp_pwm = (j < 4) ? 4'b1011 : 4'b0100;
            check($sformatf("restart pwm j=%0d", j), int'(pwm_out), int'(exp_pwm));
            check($sformatf("restart tick j=%0d", j), int'(period_tick), int'(j == 7));
        end

        // Asynchronous reset with an update pending.
        do_load(8'd5, {4{8'd1}}, 4'b0000, 1'b0);
        check("pre-reset pending", int'(update_pending), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset pwm_out", int'(pwm_out), 0);
        check("async reset period_tick", int'(period_tick), 0);
        check("async reset update_pending", int'(update_pending), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            c       = (k - 1) % 10;
            exp_pwm = (c < 6) ? 4'b1111 : 4'b0000;
            check($sformatf("post-reset pwm k=%0d", k), int'(pwm_out), int'(exp_pwm));
            check($sformatf("post-reset tick k=%0d", k), int'(period_tick), int'(c == 9));
            check($sformatf("post-reset pending k=%0d", k), int'(update_pending), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
